memory_port_arbiter: RTL

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// Two-port (core / loader) arbiter in front of a shared single-port memory.
// Round-robin on ties, boot mode locks out the core, per-transaction timeout raises err.
module memory_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [31:0]       m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_L, DONE} state_t;

  state_t              state, state_nx;
  logic                owner_l;
  logic                last_l;
  logic [CNT_W-1:0]    cnt;
  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                gnt_c_q, gnt_l_q, err_q;
  logic [DATA_W-1:0]   rdata_c_q, rdata_l_q;

  logic                c_elig, l_elig, pick_l, busy, timeout_hit;
  logic [DATA_W-1:0]   done_data;

  assign c_elig      = c_req & ~boot;
  assign l_elig      = l_req;
  // Loader wins when it is alone, or on a tie when the core was granted last.
  assign pick_l      = l_elig & (~c_elig | ~last_l);
  assign busy        = (state == BUSY_C) || (state == BUSY_L);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT)) && !m_ready;
  assign done_data   = (m_ready && !lat_we) ? m_rdata : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:           if (c_elig || l_elig) state_nx = pick_l ? BUSY_L : BUSY_C;
      BUSY_C, BUSY_L: if (m_ready || timeout_hit) state_nx = DONE;
      DONE:           state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_l   <= 1'b0;
      last_l    <= 1'b1;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt_c_q   <= 1'b0;
      gnt_l_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_c_q <= '0;
      rdata_l_q <= '0;
    end else begin
      state   <= state_nx;
      gnt_c_q <= (state == IDLE) && (state_nx == BUSY_C);
      gnt_l_q <= (state == IDLE) && (state_nx == BUSY_L);
      err_q   <= busy && timeout_hit;
      if ((state == IDLE) && (state_nx != IDLE)) begin
        lat_we    <= pick_l ? l_we    : c_we;
        lat_addr  <= pick_l ? l_addr  : c_addr;
        lat_wdata <= pick_l ? l_wdata : c_wdata;
        owner_l   <= pick_l;
        last_l    <= pick_l;
        cnt       <= '0;
      end else if (busy && !m_ready && !timeout_hit) begin
        cnt <= cnt + CNT_W'(1);
      end
      // Only the owner's read-data register moves; the other port keeps its last value.
      if (busy && (state_nx == DONE)) begin
        if (owner_l) rdata_l_q <= done_data;
        else         rdata_c_q <= done_data;
      end
    end
  end

  assign m_req    = busy;
  assign m_we     = lat_we;
  assign m_addr   = lat_addr;
  assign m_wdata  = lat_wdata;
  assign c_gnt    = gnt_c_q;
  assign l_gnt    = gnt_l_q;
  assign c_rvalid = (state == DONE) && !owner_l;
  assign l_rvalid = (state == DONE) && owner_l;
  assign c_rdata  = rdata_c_q;
  assign l_rdata  = rdata_l_q;
  assign err      = err_q;

endmodule
